// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Issue / writeback bundle between the issuing control and muldiv_unit.
//   slave  modport : seen by the execution unit
//   master modport : seen by the issuer
// Signals:
//   i_start     issue request (sampled only while the unit is idle)
//   i_funct3    RV32M operation select
//   i_rs1_data  operand A (multiplicand / dividend)
//   i_rs2_data  operand B (multiplier / divisor)
//   i_rd_addr   destination register
//   i_flush     abort the in-flight operation, suppress writeback
//   o_busy      unit occupied, issuer must stall
//   o_rd_wren   one-cycle register-file write strobe
//   o_rd_addr   writeback destination
//   o_rd_data   writeback data
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [4:0]      i_rd_addr;
  logic            i_flush;
  logic            o_busy;
  logic            o_rd_wren;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_data;

  modport slave (
    input  i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
    output o_busy, o_rd_wren, o_rd_addr, o_rd_data
  );

  modport master (
    output i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
    input  o_busy, o_rd_wren, o_rd_addr, o_rd_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Operands are captured in IDLE,
// converted to magnitudes, processed one bit per cycle for XLEN cycles
// (shift-add multiply / restoring divide), then sign-corrected and presented
// as a single-cycle register-file write in DONE.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      muldiv_if.slave (issue, flush, busy and writeback signals)
//
// Optional feature: define MULDIV_FAST_ZERO_EN to skip the iterative phase
// when a divide has a zero divisor or a multiply has a zero operand; the
// result is then available in the cycle right after capture.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_addr_q;
  // Multiply: hi_q accumulates the upper half, lo_q holds the multiplier that
  // is shifted out while product bits are shifted in.
  // Divide:   hi_q is the partial remainder, lo_q holds the dividend that is
  // shifted out while quotient bits are shifted in.
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand magnitude or divisor magnitude
  logic            neg_q;    // final result must be negated
  logic            busy_q;
  logic            wren_q;
  logic [4:0]      out_addr_q;
  logic [XLEN-1:0] out_data_q;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v,
                                            input logic n);
    neg_x = n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v,
                                               input logic n);
    neg_2x = n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  // Capture-side operand decode
  logic            cap_div;
  logic            signed_a;
  logic            signed_b;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            cap_neg;

  always_comb begin
    cap_div  = bus.i_funct3[2];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
    signed_a = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010) ||
               (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b110);
    signed_b = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b100) ||
               (bus.i_funct3 == 3'b110);
    sign_a   = signed_a & bus.i_rs1_data[XLEN-1];
    sign_b   = signed_b & bus.i_rs2_data[XLEN-1];
    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude 2^(XLEN-1).
    mag_a    = neg_x(bus.i_rs1_data, sign_a);
    mag_b    = neg_x(bus.i_rs2_data, sign_b);
    if (!cap_div) begin
      cap_neg = sign_a ^ sign_b;
    end else if (bus.i_funct3[1]) begin
      // remainder takes the sign of the dividend
      cap_neg = sign_a;
    end else begin
      // divide by zero must yield all ones, so the quotient is never negated
      cap_neg = (sign_a ^ sign_b) && (bus.i_rs2_data != '0);
    end
  end

`ifdef MULDIV_FAST_ZERO_EN
  logic            zero_op;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    if (cap_div) begin
      zero_op  = (bus.i_rs2_data == '0);
      fast_res = bus.i_funct3[1] ? bus.i_rs1_data : '1;
    end else begin
      zero_op  = (bus.i_rs1_data == '0) || (bus.i_rs2_data == '0);
      fast_res = '0;
    end
  end
`endif

  // One iteration of the datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!funct3_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      // no borrow: divisor fits, keep the difference and set the quotient bit
      step_hi = div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Final result selection with sign correction
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_data;

  always_comb begin
    prod_s = neg_2x({hi_q, lo_q}, neg_q);
    if (!funct3_q[2]) begin
      res_data = (funct3_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else begin
      res_data = neg_x(funct3_q[1] ? hi_q : lo_q, neg_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      rd_addr_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      wren_q     <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wren_q <= 1'b0;
          if (!bus.i_flush && bus.i_start) begin
            funct3_q  <= bus.i_funct3;
            rd_addr_q <= bus.i_rd_addr;
            hi_q      <= '0;
            lo_q      <= cap_div ? mag_a : mag_b;
            opnd_q    <= cap_div ? mag_b : mag_a;
            neg_q     <= cap_neg;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
`ifdef MULDIV_FAST_ZERO_EN
            if (zero_op) begin
              state_q    <= DONE;
              out_data_q <= fast_res;
              out_addr_q <= bus.i_rd_addr;
              wren_q     <= (bus.i_rd_addr != 5'd0);
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          if (bus.i_flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(XLEN)) begin
            // all iterations done: register the corrected result
            state_q    <= DONE;
            out_data_q <= res_data;
            out_addr_q <= rd_addr_q;
            wren_q     <= (rd_addr_q != 5'd0);
          end else begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wren_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  // flush kills a pending write in the very cycle it is seen
  assign bus.o_rd_wren = wren_q & ~bus.i_flush;
  assign bus.o_rd_addr = out_addr_q;
  assign bus.o_rd_data = out_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and watch the unit for the whole window, then check the
  // latency, the single strobe, the busy duration and the written value.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input bit poke);
    bit              zero;
    int              exp_first;
    int              first;
    int              nw;
    int              nb;
    logic [XLEN-1:0] data;
    logic [4:0]      addr;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = f3;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_rd_addr  = rd;
    @(negedge clk);
    bus.i_start = 1'b0;
    zero      = f3[2] ? (b == 0) : ((a == 0) || (b == 0));
    exp_first = (FAST && zero) ? 0 : XLEN + 1;
    first = -1; nw = 0; nb = 0; data = '0; addr = '0;
    for (int k = 0; k < XLEN + 5; k++) begin
      if (poke && k == 5) begin
        bus.i_start    = 1'b1;
        bus.i_funct3   = 3'b000;
        bus.i_rs1_data = 32'd100;
        bus.i_rs2_data = 32'd100;
        bus.i_rd_addr  = 5'd9;
      end else if (poke && k == 6) begin
        bus.i_start = 1'b0;
      end
      if (bus.o_busy === 1'b1) nb++;
      if (bus.o_rd_wren === 1'b1) begin
        nw++;
        if (first < 0) begin
          first = k;
          data  = bus.o_rd_data;
          addr  = bus.o_rd_addr;
        end
      end
      @(negedge clk);
    end
    chk({tag, "_wren_cnt"}, 32'(nw), {31'b0, (rd != 5'd0)});
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_first + 1));
    chk({tag, "_idle_after"}, {31'b0, bus.o_busy}, 32'd0);
    if (rd != 5'd0) begin
      chk({tag, "_latency"}, 32'(first), 32'(exp_first));
      chk({tag, "_data"}, data, exp);
      chk({tag, "_addr"}, {27'b0, addr}, {27'b0, rd});
    end
  endtask

  initial begin
    int nw;
    bus.i_start    = 1'b0;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_rd_addr  = '0;
    bus.i_flush    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rst_wren", {31'b0, bus.o_rd_wren}, 32'd0);
    chk("rst_addr", {27'b0, bus.o_rd_addr}, 32'd0);
    chk("rst_data", bus.o_rd_data, 32'd0);
    rst_n = 1'b1;

    run_op("mul",     3'b000, 32'd7,        32'd6,        5'd5, 32'd42,       1'b0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 1'b0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, 1'b0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD, 1'b0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 1'b0);
    run_op("divu",    3'b101, 32'hFFFFFFFF, 32'd2,        5'd7, 32'h7FFFFFFF, 1'b0);
    run_op("remu",    3'b111, 32'd7,        32'd3,        5'd8, 32'd1,        1'b0);
    run_op("div_z",   3'b100, 32'd9,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b0);
    run_op("rem_z",   3'b110, 32'd9,        32'd0,        5'd11, 32'd9,       1'b0);
    run_op("div_neg_z", 3'b100, 32'hFFFFFFF7, 32'd0,      5'd12, 32'hFFFFFFFF, 1'b0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,       1'b0);
    run_op("mul_zero", 3'b000, 32'd0,       32'd5,        5'd15, 32'd0,       1'b0);
    run_op("mul_rd0", 3'b000, 32'd3,        32'd3,        5'd0, 32'd0,        1'b0);
    run_op("restart_ignored", 3'b000, 32'd7, 32'd6,       5'd5, 32'd42,       1'b1);

    // flush after ten iterations: no write, idle next cycle
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = 3'b100;
    bus.i_rs1_data = 32'd100;
    bus.i_rs2_data = 32'd7;
    bus.i_rd_addr  = 5'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_calc_idle", {31'b0, bus.o_busy}, 32'd0);
    nw = 0;
    for (int k = 0; k < XLEN + 5; k++) begin
      if (bus.o_rd_wren === 1'b1) nw++;
      @(negedge clk);
    end
    chk("flush_calc_nowrite", 32'(nw), 32'd0);
    run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);

    // flush together with start in IDLE: nothing captured
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_flush    = 1'b1;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = 32'd2;
    bus.i_rs2_data = 32'd2;
    bus.i_rd_addr  = 5'd4;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_idle_busy", {31'b0, bus.o_busy}, 32'd0);
    nw = 0;
    for (int k = 0; k < XLEN + 5; k++) begin
      if (bus.o_rd_wren === 1'b1) nw++;
      @(negedge clk);
    end
    chk("flush_idle_nowrite", 32'(nw), 32'd0);

    // flush during DONE masks the strobe combinationally
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = 32'd2;
    bus.i_rs2_data = 32'd3;
    bus.i_rd_addr  = 5'd4;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (XLEN + 1) @(negedge clk);
    chk("done_wren", {31'b0, bus.o_rd_wren}, 32'd1);
    chk("done_data", bus.o_rd_data, 32'd6);
    bus.i_flush = 1'b1;
    #1;
    chk("done_flush_mask", {31'b0, bus.o_rd_wren}, 32'd0);
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("done_flush_idle", {31'b0, bus.o_busy}, 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = 32'd7;
    bus.i_rs2_data = 32'd6;
    bus.i_rd_addr  = 5'd5;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_areset_busy", {31'b0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("areset_wren", {31'b0, bus.o_rd_wren}, 32'd0);
    chk("areset_data", bus.o_rd_data, 32'd0);
    chk("areset_addr", {27'b0, bus.o_rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 3'b000, 32'd3, 32'd5, 5'd2, 32'd15, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits between the register file read ports and the register file write port.
- Consumes rs1/rs2 operand data.
- After a fixed multi-cycle computation, produces a single-cycle write (rd address, data, write enable) that drives the register file write port directly.
- The issuing control stalls on o_busy.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  issue request; sampled only in IDLE
- i_funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_data  input  XLEN  operand A (multiplicand/dividend)
- i_rs2_data  input  XLEN  operand B (multiplier/divisor)
- i_rd_addr  input  5  destination register
- i_flush  input  1  abort in-flight op, no writeback
- o_busy  output  1  unit occupied; issuer must stall
- o_rd_wren  output  1  one-cycle writeback strobe to register file
- o_rd_addr  output  5  writeback destination
- o_rd_data  output  XLEN  writeback data

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset state: FSM=IDLE, counter=0, all internal registers 0, o_busy=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - i_start=1 at edge E0 → capture funct3, rd_addr, operands; go to CALC; counter=0.
  - Sign handling at capture:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
    - All others: unsigned.
  - Signed operands are converted to magnitudes; the result sign is recorded.
- CALC:
  - One iteration per edge, XLEN iterations total (edges E1..EXLEN). Counter increments per iteration.
  - Multiply: shift-add over a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the last iteration go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate if the result sign is negative) and select the result:
    - MUL: product[XLEN-1:0].
    - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
    - DIV/DIVU: quotient. Quotient sign = signA XOR signB.
    - REM/REMU: remainder. Remainder sign = sign of dividend.
  - The registered result appears on o_rd_data and o_rd_addr for the whole DONE cycle.
  - o_rd_wren=1 for exactly that one cycle, and only if rd_addr≠0. rd_addr=0 still runs full latency with no strobe.
  - Next edge: go to IDLE; o_rd_wren returns to 0; o_rd_data holds its last value.
- Latency: capture at E0; o_rd_wren high in the cycle following edge EXLEN+1; register file writes at edge EXLEN+2.
- o_busy: 1 from the cycle after E0 through the DONE cycle inclusive; 0 in IDLE. Back-to-back issue is accepted on the first IDLE cycle.
- i_start while not IDLE is ignored; operands are not re-sampled.
- Divide by zero (RISC-V defined results, full latency):
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = dividend.
- Signed overflow (DIV with -2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0.
- Sign correction must never rely on XLEN+1-bit overflow wrap except as above.
- i_flush:
  - In CALC or DONE: next edge → IDLE, o_rd_wren forced 0 in the same cycle it is sampled (combinational mask), no write.
  - In IDLE: flush has priority over i_start; nothing is captured.
- Async reset mid-operation: immediate return to reset state; no writeback.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN
- Defined:
  - In IDLE, if i_start is sampled with rs2=0 on a divide op, or with either operand 0 on a multiply op, the FSM skips CALC and goes directly to DONE.
  - The result (div-by-zero value, or 0 for multiply) appears 1 cycle after capture; o_busy is high only for the DONE cycle.
- Undefined: every op takes full XLEN-iteration latency regardless of operands.

Test Plan:
- MUL rs1=7, rs2=6, rd=5 → o_rd_wren single-cycle pulse XLEN+1 cycles after capture, o_rd_addr=5, o_rd_data=42; o_busy high throughout.
- MULH rs1=0x80000000, rs2=0x80000000 → 0x40000000. MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU 7/3 → 1.
- DIV by zero rs1=9 → 0xFFFFFFFF; REM by zero → 9. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. Latency is full XLEN+1, or 1 cycle with MULDIV_FAST_ZERO_EN.
- i_start pulsed again mid-CALC with different operands → ignored, first result written. i_flush at iteration 10 → no o_rd_wren; unit idle next cycle; new op accepted.
- rd=0 MUL 3×3 → o_busy full duration, o_rd_wren never 1. i_rst_n dropped mid-CALC → o_busy=0, o_rd_wren=0, o_rd_data=0 immediately.
